magcomp_result_stage: RTL and testbench
=======================================

Name: magcomp_result_stage

Overview:
Registered, handshaked stage directly downstream of the 4-bit combinational magnitude comparator. Each cycle it can accept one operand pair plus the comparator's flags: z = equal, x = a greater, y = a less. Results are buffered in a 2-entry FIFO with valid/ready flow control. It also keeps saturating per-outcome statistics and a sticky flag for flag-integrity errors. It is the timing boundary between the combinational compare path and downstream consumers.

Parameters:
CNT_W, 8, width of each outcome counter (minimum 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
clr  input  1  synchronous clear of FIFO, counters and error flag
in_valid  input  1  upstream has a pair/flags to deliver
in_ready  output  1  stage can accept this cycle
a  input  4  operand A as presented to comparator
b  input  4  operand B as presented to comparator
z  input  1  comparator equal flag
x  input  1  comparator A>B flag
y  input  1  comparator A<B flag
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head entry
out_a  output  4  head entry operand A
out_b  output  4  head entry operand B
out_z  output  1  head entry equal flag
out_x  output  1  head entry A>B flag
out_y  output  1  head entry A<B flag
eq_cnt  output  CNT_W  accepted equal outcomes, saturating
gt_cnt  output  CNT_W  accepted A>B outcomes, saturating
lt_cnt  output  CNT_W  accepted A<B outcomes, saturating
onehot_err  output  1  sticky: an accepted {z,x,y} was not one-hot
max_val  output  4  running maximum operand (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty; out_valid=0; out_a/out_b/out_z/out_x/out_y=0; all counters=0; onehot_err=0; max_val=0. in_ready=1 from the first cycle after release.
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- FIFO: 2 entries of 11 bits {a,b,z,x,y}, with registered head, tail pointer and occupancy count (0..2).
- in_ready = (count < 2). It depends only on registered state; there is no combinational path from out_ready.
- out_valid = (count > 0). out_* show the head entry and are held stable while out_valid & !out_ready.
- Latency: a pair pushed into an empty FIFO in cycle N gives out_valid=1 in cycle N+1.
- Simultaneous push and pop at count=1: occupancy stays 1, head advances to the new entry, and order is preserved.
- At count=2, in_ready=0, so a pop frees a slot that is usable in the following cycle.
- A pop at count=0 is impossible because out_valid=0.
- Counters update on push only:
  - {z,x,y}=100 increments eq_cnt; 010 increments gt_cnt; 001 increments lt_cnt.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- Integrity check: a push with {z,x,y} not in {100,010,001} sets onehot_err=1 (sticky). The entry is still stored and forwarded unchanged. No counter increments for it.
- clr (synchronous, cycle of assertion): empties the FIFO, zeroes counters, clears onehot_err and max_val. clr has priority over a simultaneous push or pop.
  - A push offered during clr is dropped and not counted.
  - in_ready remains as computed from pre-clear state, so the upstream must treat clr cycles as discarding.
- Reset mid-operation discards all buffered entries immediately, because reset is asynchronous.

Optional Feature:
MAGCOMP_MAX_TRACK_EN
- Defined: on each push, the larger operand is chosen as a when x|z, else b. max_val updates to that operand if it exceeds the current max_val. max_val is cleared by reset and clr. Pushes flagged by onehot_err still update max_val using the same rule.
- Undefined: max_val is tied to 4'h0 and no tracking logic is built. The port list is unchanged.

Test Plan:
- Reset release, push a=9 b=3 flags 010, out_ready=1 -> next cycle out_valid=1, out_a=9, out_b=3, out_x=1; gt_cnt=1; following cycle out_valid=0.
- Hold out_ready=0, push (5,5,100), (2,7,001), then offer a third pair -> in_ready=0 after the second push; the third is not accepted; eq_cnt=1, lt_cnt=1. Raise out_ready -> outputs (5,5) then (2,7) in order.
- CNT_W=2: push 5 gt pairs -> gt_cnt goes 1,2,3,3,3 (saturates, no wrap).
- Push flags 110 with a=4 b=4 -> onehot_err=1 and sticky; the entry is forwarded with out_z=out_x=1; all counters unchanged. clr -> onehot_err=0, counters=0, out_valid=0.
- Assert rst_n low mid-cycle with count=2 -> out_valid, counters and onehot_err drop to 0 immediately, without waiting for clk.
- With MAGCOMP_MAX_TRACK_EN: push (3,12,001), (9,1,010), (7,7,100) -> max_val=12 after each. Without the macro: max_val=0 throughout.

Source files
------------

// File: rtl/magcomp_result_stage.sv
// Registered valid/ready result stage behind the 4-bit magnitude comparator:
// 2-entry FIFO, saturating outcome counters, sticky one-hot error flag.
// Optional running-max tracking is enabled by defining MAGCOMP_MAX_TRACK_EN.
module magcomp_result_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             z,
    input  logic             x,
    input  logic             y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_a,
    output logic [3:0]       out_b,
    output logic             out_z,
    output logic             out_x,
    output logic             out_y,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             onehot_err,
    output logic [3:0]       max_val
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0][10:0]  mem_q, mem_d;
    logic              head_q, head_d, tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic              err_q, err_d;

    logic              push, pop;
    logic [2:0]        flags;
    logic              is_eq, is_gt, is_lt;

    // Ready/valid come only from registered occupancy, never from out_ready.
    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign flags = {z, x, y};
    assign is_eq = (flags == 3'b100);
    assign is_gt = (flags == 3'b010);
    assign is_lt = (flags == 3'b001);

    assign {out_a, out_b, out_z, out_x, out_y} = mem_q[head_q];

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        err_d   = err_q;
        if (clr) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
            eq_d    = '0;
            gt_d    = '0;
            lt_d    = '0;
            err_d   = 1'b0;
        end else begin
            if (push) begin
                mem_d[tail_q] = {a, b, z, x, y};
                tail_d        = ~tail_q;
                if (is_eq && eq_q != CNT_MAX) eq_d = eq_q + 1'b1;
                if (is_gt && gt_q != CNT_MAX) gt_d = gt_q + 1'b1;
                if (is_lt && lt_q != CNT_MAX) lt_d = lt_q + 1'b1;
                if (!(is_eq || is_gt || is_lt)) err_d = 1'b1;
            end
            if (pop) head_d = ~head_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            eq_q    <= '0;
            gt_q    <= '0;
            lt_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
        end
    end

    assign eq_cnt     = eq_q;
    assign gt_cnt     = gt_q;
    assign lt_cnt     = lt_q;
    assign onehot_err = err_q;

`ifdef MAGCOMP_MAX_TRACK_EN
    logic [3:0] max_q, max_d;
    logic [3:0] larger;

    // Selection follows the flags as delivered, even when they are not one-hot.
    assign larger = (x | z) ? a : b;

    always_comb begin
        max_d = max_q;
        if (clr)                        max_d = 4'h0;
        else if (push && larger > max_q) max_d = larger;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) max_q <= 4'h0;
        else        max_q <= max_d;
    end

    assign max_val = max_q;
`else
    assign max_val = 4'h0;
`endif

endmodule

// File: tb/tb_magcomp_result_stage.sv
// Directed bench for magcomp_result_stage (CNT_W=2 so saturation is reachable):
// a vector table for single pushes plus hand-written multi-cycle sequences.
module tb_magcomp_result_stage;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n, clr, in_valid, in_ready;
    logic [3:0]       a, b;
    logic             z, x, y;
    logic             out_valid, out_ready;
    logic [3:0]       out_a, out_b;
    logic             out_z, out_x, out_y;
    logic [CNT_W-1:0] eq_cnt, gt_cnt, lt_cnt;
    logic             onehot_err;
    logic [3:0]       max_val;

    int checks = 0;
    int errors = 0;

    magcomp_result_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .z(z), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_z(out_z), .out_x(out_x), .out_y(out_y),
        .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt),
        .onehot_err(onehot_err), .max_val(max_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a, b;
        logic [2:0] f;
        int         eq, gt, lt, err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] aa, input logic [3:0] bb,
                         input logic [2:0] f);
        in_valid = v;
        a = aa;
        b = bb;
        {z, x, y} = f;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input int e, input int g, input int l);
        chk({tag, " eq_cnt"}, int'(eq_cnt), e);
        chk({tag, " gt_cnt"}, int'(gt_cnt), g);
        chk({tag, " lt_cnt"}, int'(lt_cnt), l);
    endtask

    int exp_max;

    initial begin
        // gt saturates at 3 for CNT_W=2
        vecs[0] = '{4'd9,  4'd3, 3'b010, 0, 1, 0, 0};
        vecs[1] = '{4'd8,  4'd1, 3'b010, 0, 2, 0, 0};
        vecs[2] = '{4'd15, 4'd0, 3'b010, 0, 3, 0, 0};
        vecs[3] = '{4'd4,  4'd2, 3'b010, 0, 3, 0, 0};
        vecs[4] = '{4'd1,  4'd0, 3'b010, 0, 3, 0, 0};
        vecs[5] = '{4'd6,  4'd6, 3'b100, 1, 3, 0, 0};
        vecs[6] = '{4'd2,  4'd7, 3'b001, 1, 3, 1, 0};
        vecs[7] = '{4'd0,  4'd0, 3'b000, 1, 3, 1, 1};

        rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        #3;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_a", int'(out_a), 0);
        chk("rst onehot_err", int'(onehot_err), 0);
        chk("rst max_val", int'(max_val), 0);
        #9 rst_n = 1'b1;
        tick();
        chk("rst in_ready", int'(in_ready), 1);
        chk_cnt("rst", 0, 0, 0);

        // Basic single push: latency 1, popped the cycle after
        out_ready = 1'b1;
        drive(1'b1, 4'd9, 4'd3, 3'b010);
        tick();
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        chk("basic out_valid", int'(out_valid), 1);
        chk("basic out_a", int'(out_a), 9);
        chk("basic out_b", int'(out_b), 3);
        chk("basic out_x", int'(out_x), 1);
        chk("basic gt_cnt", int'(gt_cnt), 1);
        tick();
        chk("basic drain", int'(out_valid), 0);

        // Table: one push, check head and stats, then let it drain
        do_clr();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].f);
            tick();
            drive(1'b0, 4'd0, 4'd0, 3'b000);
            chk($sformatf("v%0d out_valid", i), int'(out_valid), 1);
            chk($sformatf("v%0d out_a", i), int'(out_a), int'(vecs[i].a));
            chk($sformatf("v%0d out_b", i), int'(out_b), int'(vecs[i].b));
            chk($sformatf("v%0d flags", i), int'({out_z, out_x, out_y}), int'(vecs[i].f));
            chk_cnt($sformatf("v%0d", i), vecs[i].eq, vecs[i].gt, vecs[i].lt);
            chk($sformatf("v%0d onehot_err", i), int'(onehot_err), vecs[i].err);
            tick();
        end

        // Backpressure: two entries fill, third offer is refused
        do_clr();
        chk("clr err", int'(onehot_err), 0);
        chk_cnt("clr", 0, 0, 0);
        out_ready = 1'b0;
        drive(1'b1, 4'd5, 4'd5, 3'b100);
        tick();
        chk("bp in_ready 1", int'(in_ready), 1);
        drive(1'b1, 4'd2, 4'd7, 3'b001);
        tick();
        chk("bp in_ready full", int'(in_ready), 0);
        drive(1'b1, 4'd1, 4'd1, 3'b100);
        tick();
        chk("bp held in_ready", int'(in_ready), 0);
        chk("bp held out_a", int'(out_a), 5);
        chk_cnt("bp", 1, 0, 1);
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        out_ready = 1'b1;
        chk("bp head0 a", int'(out_a), 5);
        chk("bp head0 b", int'(out_b), 5);
        tick();
        chk("bp head1 a", int'(out_a), 2);
        chk("bp head1 b", int'(out_b), 7);
        chk("bp head1 y", int'(out_y), 1);
        chk("bp freed", int'(in_ready), 1);
        tick();
        chk("bp empty", int'(out_valid), 0);
        chk_cnt("bp end", 1, 0, 1);

        // Simultaneous push/pop at count 1: head advances to the new entry
        out_ready = 1'b0;
        drive(1'b1, 4'd3, 4'd1, 3'b010);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 4'd1, 4'd8, 3'b001);
        tick();
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        chk("pp out_valid", int'(out_valid), 1);
        chk("pp head a", int'(out_a), 1);
        chk("pp head b", int'(out_b), 8);
        tick();
        chk("pp empty", int'(out_valid), 0);

        // Non-one-hot flags: stored unchanged, sticky error, no counting
        do_clr();
        out_ready = 1'b0;
        drive(1'b1, 4'd4, 4'd4, 3'b110);
        tick();
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        chk("oh err", int'(onehot_err), 1);
        chk("oh flags", int'({out_z, out_x, out_y}), 6);
        chk_cnt("oh", 0, 0, 0);
        out_ready = 1'b1;
        tick();
        chk("oh sticky", int'(onehot_err), 1);
        chk("oh drained", int'(out_valid), 0);
        do_clr();
        chk("oh clr err", int'(onehot_err), 0);

        // Push during clr is dropped and not counted
        out_ready = 1'b0;
        drive(1'b1, 4'd7, 4'd7, 3'b100);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        chk("clrpush out_valid", int'(out_valid), 0);
        chk("clrpush eq_cnt", int'(eq_cnt), 0);

        // Running maximum
        out_ready = 1'b1;
`ifdef MAGCOMP_MAX_TRACK_EN
        exp_max = 12;
`else
        exp_max = 0;
`endif
        drive(1'b1, 4'd3, 4'd12, 3'b001);
        tick();
        chk("max 1", int'(max_val), exp_max);
        drive(1'b1, 4'd9, 4'd1, 3'b010);
        tick();
        chk("max 2", int'(max_val), exp_max);
        drive(1'b1, 4'd7, 4'd7, 3'b100);
        tick();
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        chk("max 3", int'(max_val), exp_max);
        tick();

        // Asynchronous reset with a full FIFO
        do_clr();
        out_ready = 1'b0;
        drive(1'b1, 4'd9, 4'd2, 3'b010);
        tick();
        drive(1'b1, 4'd0, 4'd0, 3'b011);
        tick();
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        chk("ar full", int'(in_ready), 0);
        chk("ar pre err", int'(onehot_err), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar out_valid", int'(out_valid), 0);
        chk("ar gt_cnt", int'(gt_cnt), 0);
        chk("ar err", int'(onehot_err), 0);
        chk("ar out_a", int'(out_a), 0);
        #3 rst_n = 1'b1;
        tick();
        chk("ar in_ready", int'(in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
